// File: rtl/ubutterfly_stream_decoder.sv
// Counts four unary bitstreams over 2^BITWIDTH enabled cycles and presents
// the (optionally bipolar) counts on a valid/ready output register.
module ubutterfly_stream_decoder #(
    parameter int BITWIDTH = 8,
    parameter bit BIPOLAR  = 1'b1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iReal0,
    input  logic                iImg0,
    input  logic                iReal1,
    input  logic                iImg1,
    input  logic                iReady,
    output logic [BITWIDTH:0]   oReal0,
    output logic [BITWIDTH:0]   oImg0,
    output logic [BITWIDTH:0]   oReal1,
    output logic [BITWIDTH:0]   oImg1,
    output logic                oValid,
    output logic                oOvf,
    output logic                oBusy
);

    localparam int W = BITWIDTH + 1;
    localparam logic [W-1:0] HALF = W'(1 << (BITWIDTH - 1));

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                 state_q, state_d;
    logic [BITWIDTH-1:0]    cnt_q, cnt_d;
    logic [3:0][W-1:0]      acc_q, acc_d;
    logic [3:0][W-1:0]      res_q, res_d;
    logic [3:0][W-1:0]      fin;
    logic                   ovf_q, ovf_d;
    logic [3:0]             bits;
    logic                   done;

    assign bits = {iImg1, iReal1, iImg0, iReal0};
    assign done = iEn && (cnt_q == {BITWIDTH{1'b1}});

    // Final frame value includes the bit arriving on the last enabled cycle
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fin[i] = acc_q[i] + W'(bits[i]);
            if (BIPOLAR) begin
                fin[i] = fin[i] - HALF;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (iClr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (iEn) begin
            cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < 4; i++) begin
                acc_d[i] = done ? '0 : acc_q[i] + W'(bits[i]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        if (iClr) begin
            state_d = EMPTY;
            res_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (done) begin
                        state_d = FULL;
                        res_d   = fin;
                    end
                end
                FULL: begin
                    if (done && iReady) begin
                        res_d = fin;
                    end else if (done) begin
                        ovf_d = 1'b1;
                    end else if (iReady) begin
                        state_d = EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oReal0 = res_q[0];
    assign oImg0  = res_q[1];
    assign oReal1 = res_q[2];
    assign oImg1  = res_q[3];
    assign oValid = (state_q == FULL);
    assign oOvf   = ovf_q;
    assign oBusy  = |cnt_q;

endmodule

// File: tb/tb_ubutterfly_stream_decoder.sv
// Randomized and directed bench for ubutterfly_stream_decoder, bipolar and
// raw instances side by side against a frame-level reference model.
module tb_ubutterfly_stream_decoder;

    localparam int BW = 8;
    localparam int N  = 1 << BW;
    localparam int W  = BW + 1;

    logic clk = 1'b0;
    logic rst, en, clr, r0, i0, r1, i1, rdy;
    logic [W-1:0] bip_o [4];
    logic [W-1:0] raw_o [4];
    logic b_valid, b_ovf, b_busy;
    logic r_valid, r_ovf, r_busy;

    always #5 clk = ~clk;

    ubutterfly_stream_decoder #(.BITWIDTH(BW), .BIPOLAR(1'b1)) u_bip (
        .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr),
        .iReal0(r0), .iImg0(i0), .iReal1(r1), .iImg1(i1),
        .iReady(rdy),
        .oReal0(bip_o[0]), .oImg0(bip_o[1]),
        .oReal1(bip_o[2]), .oImg1(bip_o[3]),
        .oValid(b_valid), .oOvf(b_ovf), .oBusy(b_busy)
    );

    ubutterfly_stream_decoder #(.BITWIDTH(BW), .BIPOLAR(1'b0)) u_raw (
        .iClk(clk), .iRst(rst), .iEn(en), .iClr(clr),
        .iReal0(r0), .iImg0(i0), .iReal1(r1), .iImg1(i1),
        .iReady(rdy),
        .oReal0(raw_o[0]), .oImg0(raw_o[1]),
        .oReal1(raw_o[2]), .oImg1(raw_o[3]),
        .oValid(r_valid), .oOvf(r_ovf), .oBusy(r_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: ones counted per frame, result slot with overflow
    int       m_cnt;
    int       m_ones [4];
    bit       m_valid, m_ovf;
    logic [W-1:0] e_raw [4];
    logic [W-1:0] e_bip [4];

    function automatic void model_reset();
        m_cnt   = 0;
        m_valid = 0;
        m_ovf   = 0;
        for (int k = 0; k < 4; k++) begin
            m_ones[k] = 0;
            e_raw[k]  = '0;
            e_bip[k]  = '0;
        end
    endfunction

    function automatic void model_step();
        bit b [4];
        bit done, xfer;
        b = '{r0, i0, r1, i1};
        if (clr) begin
            model_reset();
            return;
        end
        done = en && (m_cnt == N - 1);
        xfer = m_valid && rdy;
        if (en) begin
            for (int k = 0; k < 4; k++) m_ones[k] += int'(b[k]);
            m_cnt++;
        end
        if (done) begin
            if (!m_valid || rdy) begin
                for (int k = 0; k < 4; k++) begin
                    e_raw[k] = W'(m_ones[k]);
                    e_bip[k] = W'(m_ones[k] - N / 2);
                end
                m_valid = 1;
            end else begin
                m_ovf = 1;
            end
            for (int k = 0; k < 4; k++) m_ones[k] = 0;
            m_cnt = 0;
        end else if (xfer) begin
            m_valid = 0;
        end
    endfunction

    task automatic check_all();
        check("valid", b_valid, m_valid);
        check("ovf", b_ovf, m_ovf);
        check("busy", b_busy, m_cnt != 0);
        check("raw_valid", r_valid, m_valid);
        check("raw_ovf", r_ovf, m_ovf);
        check("raw_busy", r_busy, m_cnt != 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bip%0d", k), bip_o[k], e_bip[k]);
            check($sformatf("raw%0d", k), raw_o[k], e_raw[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_bits(input logic [3:0] b);
        {i1, r1, i0, r0} = b;
    endtask

    int sa [4];
    logic [3:0] rb;

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b0;
        set_bits(4'h0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // All-ones frame, raw count N, bipolar +N/2
        en = 1'b1; rdy = 1'b1; set_bits(4'hF);
        repeat (N - 1) tick();
        check("t1_pre_valid", b_valid, 1'b0);
        tick();
        check("t1_valid", b_valid, 1'b1);
        check("t1_raw0", raw_o[0], 9'd256);
        check("t1_raw3", raw_o[3], 9'd256);
        check("t1_bip0", bip_o[0], 9'h080);
        en = 1'b0;
        tick();
        check("t1_drop", b_valid, 1'b0);

        // Bipolar pattern: alternating, zeros, ones, 192 ones
        en = 1'b1;
        for (int k = 0; k < N; k++) begin
            r0 = (k % 2 == 0); i0 = 1'b0; r1 = 1'b1; i1 = (k < 192);
            tick();
        end
        check("t2_re0", bip_o[0], 9'h000);
        check("t2_im0", bip_o[1], 9'h180);
        check("t2_re1", bip_o[2], 9'h080);
        check("t2_im1", bip_o[3], 9'h040);
        check("t2_busy", b_busy, 1'b0);
        en = 1'b0;
        tick();

        // Enable toggled every cycle: one frame over 512 clocks
        set_bits(4'hF);
        for (int k = 0; k < 2 * N; k++) begin
            en = (k % 2 == 0);
            tick();
            if (k == 2 * N - 3) check("t3_early", b_valid, 1'b0);
            if (k == 2 * N - 2) begin
                check("t3_valid", b_valid, 1'b1);
                check("t3_bip", bip_o[2], 9'h080);
            end
        end

        // Two frames unconsumed: first kept, overflow sticky
        rdy = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) sa[k] = 0;
        for (int k = 0; k < N; k++) begin
            rb = 4'($urandom);
            set_bits(rb);
            for (int j = 0; j < 4; j++) sa[j] += int'(rb[j]);
            tick();
        end
        check("t4_first", b_valid, 1'b1);
        for (int k = 0; k < N; k++) begin
            set_bits(4'($urandom));
            tick();
        end
        check("t4_ovf", b_ovf, 1'b1);
        for (int k = 0; k < 4; k++) check("t4_kept", raw_o[k], W'(sa[k]));
        en = 1'b0; rdy = 1'b1;
        tick();
        check("t4_taken", b_valid, 1'b0);
        check("t4_ovf_hold", b_ovf, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_ovf_clr", b_ovf, 1'b0);

        // Clear mid-frame; only post-clear bits count
        en = 1'b1;
        repeat (100) begin
            set_bits(4'($urandom));
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_busy", b_busy, 1'b0);
        for (int k = 0; k < 4; k++) sa[k] = 0;
        for (int k = 0; k < N; k++) begin
            rb = 4'($urandom);
            set_bits(rb);
            for (int j = 0; j < 4; j++) sa[j] += int'(rb[j]);
            if (k == N - 1) check("t5_pre", b_valid, 1'b0);
            tick();
        end
        check("t5_valid", b_valid, 1'b1);
        for (int k = 0; k < 4; k++) check("t5_cnt", raw_o[k], W'(sa[k]));

        // Async reset with a held result and a frame in progress
        rdy = 1'b0; en = 1'b1; set_bits(4'hF);
        repeat (N + 50) tick();
        check("t6_held", b_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", b_valid, 1'b0);
        check("t6_async_busy", b_busy, 1'b0);
        check("t6_async_data", bip_o[0], 9'h000);
        check("t6_async_raw", raw_o[3], 9'h000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        rdy = 1'b1;
        repeat (N - 1) tick();
        check("t6_pre", b_valid, 1'b0);
        tick();
        check("t6_done", b_valid, 1'b1);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            en  = ($urandom_range(3) != 0);
            rdy = $urandom_range(1);
            clr = ($urandom_range(199) == 0);
            set_bits(4'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ubutterfly_stream_decoder.md
Name: ubutterfly_stream_decoder

Overview:
- Output-end converter for the unary FFT datapath.
- Consumes the four bitstreams produced by a unary butterfly stage (Real0, Img0, Real1, Img1). Each stream is counted over one frame of 2^BITWIDTH enabled cycles.
- Presents the four binary results with a valid/ready handshake toward binary post-processing or the next FFT stage's binary-to-unary loader.

Parameters:
- BITWIDTH, 8, log2 of frame length; frame N = 2^BITWIDTH enabled cycles.
- BIPOLAR, 1, 0 = output raw ones-count; 1 = output ones-count minus N/2 (two's complement, bipolar decode).

Ports:
- iClk  in  1  clock; all state on rising edge.
- iRst  in  1  reset; asynchronous, active-high.
- iEn  in  1  stream bits valid this cycle; counters advance only when high.
- iClr  in  1  synchronous frame abort; clears accumulators, cycle counter, oValid, oOvf.
- iReal0  in  1  unary stream bit.
- iImg0  in  1  unary stream bit.
- iReal1  in  1  unary stream bit.
- iImg1  in  1  unary stream bit.
- iReady  in  1  downstream accepts result when high with oValid.
- oReal0  out  BITWIDTH+1  decoded result, held stable while oValid.
- oImg0  out  BITWIDTH+1  decoded result, held stable while oValid.
- oReal1  out  BITWIDTH+1  decoded result, held stable while oValid.
- oImg1  out  BITWIDTH+1  decoded result, held stable while oValid.
- oValid  out  1  result registers hold an unconsumed frame.
- oOvf  out  1  sticky: a completed frame was dropped because the previous one was unconsumed.
- oBusy  out  1  high when cycle counter is non-zero (frame in progress).

Behaviour:
- Reset (iRst=1, async): cycle counter, four accumulators, all outputs = 0. Takes effect immediately and overrides everything, mid-frame included.
- Priority: iRst > iClr > frame completion > handshake.
- Accumulators: BITWIDTH+1 bits each, unsigned. On iEn=1 each accumulator adds its input bit. Cycle counter (BITWIDTH bits) increments and wraps naturally.
- iEn=0: counters and accumulators frozen. Stream bits are ignored.
- Frame completion: iEn=1 and cycle counter = N-1.
  - Final value = accumulator + current bit (range 0..N, so no overflow in BITWIDTH+1 bits).
  - If BIPOLAR=1, subtract N/2; result range -N/2..+N/2.
  - Result is registered into the output registers next edge, and oValid=1 from that edge (latency 1 cycle after the last bit).
  - Accumulators restart from 0 in the same edge. The counter wraps to 0, so the next frame starts immediately and back-to-back frames have no gap cycles.
- Handshake:
  - Transfer occurs on an edge where oValid=1 and iReady=1. oValid drops next cycle unless a completion occurs on that same edge.
  - Outputs hold their value while oValid=1 and iReady=0.
  - oValid may rise without regard to iReady. iReady while oValid=0 has no effect.
- Simultaneous completion and transfer: new result loads, oValid stays 1, no overflow.
- Completion with oValid=1 and iReady=0:
  - The new result is discarded and the old result is kept.
  - oOvf set to 1 and held until iClr or iRst.
  - Accumulators still restart.
- iClr=1: next edge zeroes the counter, accumulators, oValid and oOvf. Output data registers also go to 0. A frame in progress is lost, and completion in the same cycle is ignored.
- oBusy = (cycle counter != 0), purely registered-state derived.
- State machine (output side, 2 states):
  - EMPTY: oValid=0. Goes to FULL on completion.
  - FULL: oValid=1.
    - Transfer without completion: go to EMPTY.
    - Transfer with completion: stay FULL with new data.
    - Completion without transfer: stay FULL and set oOvf.
    - iClr: go to EMPTY.

Test Plan:
- BITWIDTH=8, BIPOLAR=0: all four streams 1 for 256 enabled cycles, iReady=1 -> oValid one cycle after bit 256; each output = 256; oValid high exactly one cycle.
- BIPOLAR=1: Real0 alternating 1/0, Img0 all 0, Real1 all 1, Img1 = 192 ones -> outputs 0, -128, +128, +64; oBusy=0 after completion.
- iEn toggled 1/0 every cycle for 512 clocks with all-ones streams -> exactly one frame, value 256 (or +128 if BIPOLAR=1), completing at clock 511.
- iReady held 0 across two full frames (different data) -> first frame's values retained, oOvf=1 after second completion; iReady=1 then yields first values; oOvf stays 1 until iClr pulse.
- iClr pulsed at enabled cycle 100 of a frame -> counters zero, oValid=0, oOvf=0; next oValid only after 256 further enabled cycles, with counts from post-clear bits only.
- iRst asserted asynchronously mid-cycle with oValid=1 at enabled cycle 50 -> all outputs 0 immediately without waiting for a clock edge; after deassert, first completion after 256 enabled cycles.
